light_seq: RTL and testbench

Parametrised lamp-pattern sequencer for an N-lamp display. It drives one output bit per lamp and steps through a program of patterns: all-flash, single-lamp chase, alternate, and bar fill. Step rate comes from a runtime-programmable prescaler. Mode and direction are selectable at run time. It sits between the board clock/reset and the lamp drivers, and it supersedes the fixed 8-lamp, fixed-rate sequencer.

---
 rtl/light_seq.sv | 128 ++++++++++++
 tb/tb_light_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/light_seq.sv
// rtl/light_seq.sv - N-lamp pattern sequencer with programmable step prescaler
// Steps through FLASH/CHASE/ALT/BAR patterns in auto or single-phase mode.
module light_seq #(
    parameter int N     = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    output logic [N-1:0]     q,
    output logic [1:0]       phase,
    output logic             wrap
);

    localparam int K_W = $clog2(N);

    localparam logic [1:0] PH_FLASH = 2'd0;
    localparam logic [1:0] PH_CHASE = 2'd1;
    localparam logic [1:0] PH_ALT   = 2'd2;
    localparam logic [1:0] PH_BAR   = 2'd3;

    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);
    localparam logic [K_W-1:0] K_ONE  = K_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       ptr_ph_q, ptr_ph_d;
    logic [K_W-1:0]   ptr_k_q, ptr_k_d;
    logic             pend_q, pend_d;
    logic [N-1:0]     q_q, q_d;
    logic [1:0]       phase_q, phase_d;
    logic             wrap_q, wrap_d;

    logic             tick;
    logic             restart;
    logic [1:0]       cur_ph;
    logic [K_W-1:0]   cur_k;
    logic [K_W-1:0]   ph_last_k;
    logic             end_of_phase;
    logic             seq_last;
    logic [N-1:0]     base;
    logic [N-1:0]     pat;

    always_comb begin
        tick  = en && (cnt_q >= div);
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A mode change jumps straight to the new mode's first phase; the
        // mode encoding doubles as that phase code (auto starts at FLASH).
        restart = (mode != mode_q);
        cur_ph  = restart ? mode : ptr_ph_q;
        cur_k   = restart ? '0   : ptr_k_q;

        ph_last_k    = (cur_ph == PH_FLASH || cur_ph == PH_ALT) ? K_ONE : K_LAST;
        end_of_phase = (cur_k == ph_last_k);
        seq_last     = (mode == 2'd0) ? (end_of_phase && cur_ph == PH_BAR) : end_of_phase;

        base = '0;
        for (int i = 0; i < N; i++) begin
            case (cur_ph)
                PH_FLASH: base[i] = cur_k[0];
                PH_CHASE: base[i] = (K_W'(i) == cur_k);
                PH_ALT:   base[i] = (i[0] == cur_k[0]);
                default:  base[i] = (K_W'(i) <= cur_k);
            endcase
        end
        for (int i = 0; i < N; i++) begin
            pat[i] = dir ? base[N-1-i] : base[i];
        end

        mode_d   = mode_q;
        ptr_ph_d = ptr_ph_q;
        ptr_k_d  = ptr_k_q;
        pend_d   = pend_q;
        q_d      = q_q;
        phase_d  = phase_q;
        wrap_d   = 1'b0;
        if (tick) begin
            mode_d  = mode;
            q_d     = pat;
            phase_d = cur_ph;
            wrap_d  = !restart && pend_q;
            pend_d  = seq_last;
            if (end_of_phase) begin
                ptr_k_d  = '0;
                ptr_ph_d = (mode == 2'd0) ? cur_ph + 2'd1 : cur_ph;
            end else begin
                ptr_k_d  = cur_k + 1'b1;
                ptr_ph_d = cur_ph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            mode_q   <= 2'd0;
            ptr_ph_q <= PH_FLASH;
            ptr_k_q  <= '0;
            pend_q   <= 1'b0;
            q_q      <= '0;
            phase_q  <= PH_FLASH;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            ptr_ph_q <= ptr_ph_d;
            ptr_k_q  <= ptr_k_d;
            pend_q   <= pend_d;
            q_q      <= q_d;
            phase_q  <= phase_d;
            wrap_q   <= wrap_d;
        end
    end

    assign q     = q_q;
    assign phase = phase_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_light_seq.sv
// tb/tb_light_seq.sv - randomized self-checking bench for light_seq
// Reference model tracks a position index into each mode's step program.
module tb_light_seq;

    localparam int N     = 8;
    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     q;
    logic [1:0]       phase;
    logic             wrap;

    always #5 clk = ~clk;

    light_seq #(.N(N), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .dir   (dir),
        .div   (div),
        .q     (q),
        .phase (phase),
        .wrap  (wrap)
    );

    int n_vec = 0;
    int n_err = 0;

    int m_cnt, m_mode, m_pos, m_q, m_phase;
    bit m_pend, m_wrap;

    logic [7:0] tbl [20] = '{8'h00, 8'hFF, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                             8'h55, 8'hAA, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int seq_len(input int md);
        if (md == 0) return 2 * N + 4;
        if (md == 2) return 2;
        return N;
    endfunction

    task automatic step_of(input int md, input int pos, output int ph, output int k);
        if (md != 0) begin
            ph = md; k = pos;
        end else if (pos < 2) begin
            ph = 0; k = pos;
        end else if (pos < N + 2) begin
            ph = 1; k = pos - 2;
        end else if (pos < N + 4) begin
            ph = 2; k = pos - N - 2;
        end else begin
            ph = 3; k = pos - N - 4;
        end
    endtask

    function automatic int pattern(input int ph, input int k, input bit d);
        int p, r;
        p = 0;
        case (ph)
            0: p = (k == 1) ? (1 << N) - 1 : 0;
            1: p = 1 << k;
            2: for (int i = k; i < N; i += 2) p += (1 << i);
            default: p = (1 << (k + 1)) - 1;
        endcase
        if (!d) return p;
        r = 0;
        for (int i = 0; i < N; i++)
            if ((p >> i) & 1) r += 1 << (N - 1 - i);
        return r;
    endfunction

    task automatic model_edge();
        int cur, ph, k, len;
        if (reset) begin
            m_cnt = 0; m_mode = 0; m_pos = 0; m_pend = 0;
            m_q = 0; m_phase = 0; m_wrap = 0;
        end else if (en && m_cnt >= int'(div)) begin
            m_cnt = 0;
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode);
                cur = 0;
                m_wrap = 0;
            end else begin
                cur = m_pos;
                m_wrap = m_pend;
            end
            len = seq_len(m_mode);
            step_of(m_mode, cur, ph, k);
            m_q = pattern(ph, k, dir);
            m_phase = ph;
            m_pend = (cur == len - 1);
            m_pos = (cur + 1) % len;
        end else begin
            if (en) m_cnt++;
            m_wrap = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("q", 32'(q), 32'(m_q));
        check("phase", 32'(phase), 32'(m_phase));
        check("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 2'd0; dir = 1'b0; div = '0;
        run(2);

        // Auto program, div=0, against the literal expected table
        reset = 1'b0;
        for (int j = 0; j < 21; j++) begin
            cycle();
            if (j < 20) check("tbl_q", 32'(q), 32'(tbl[j]));
            else begin
                check("tbl_wrap_q", 32'(q), 32'h00);
                check("tbl_wrap", 32'(wrap), 32'h1);
            end
        end

        // Chase only, reversed, div=3
        mode = 2'd1; dir = 1'b1; div = 24'd3;
        run(40);

        // Bar to k=4 then switch to alternate
        mode = 2'd3; dir = 1'b0; div = '0;
        run(5);
        check("bar_k4", 32'(q), 32'h1F);
        mode = 2'd2;
        run(1);
        check("alt_switch_q", 32'(q), 32'h55);
        check("alt_switch_ph", 32'(phase), 32'h2);
        run(3);

        // Enable stall mid-count, div=9
        mode = 2'd0; div = 24'd9;
        run(14);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(25);

        // Lower div while counting
        div = 24'd100;
        run(110);
        run(50);
        div = 24'd2;
        run(12);

        // Reset pulse mid auto program
        div = '0;
        run(7);
        reset = 1'b1;
        run(1);
        check("rst_q", 32'(q), 32'h0);
        reset = 1'b0;
        run(4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            en    = ($urandom_range(9) != 0);
            if ($urandom_range(29) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(19) == 0) dir = ~dir;
            if ($urandom_range(49) == 0) div = DIV_W'($urandom_range(5));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
